// File: rtl/robo_pkg.sv
// robo_pkg: shared constants and helpers for the robo_ambiente maze emulator.
//   - heading constants N/E/S/W (grid: north is y+1, east is x+1)
//   - {f,g} command encodings
//   - MAZE[0:63]: 4-bit wall nibble {N,E,S,W} per cell, indexed by {y,x}
//   - wall_nibble(): map lookup with the outer border walls forced on
//   - sat_inc16(): saturating step counter increment
package robo_pkg;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] S = 2'd2;
  localparam logic [1:0] W = 2'd3;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b10;
  localparam logic [1:0] CMD_TURN = 2'b01;
  localparam logic [1:0] CMD_ERR  = 2'b11;

  typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

  typedef logic [3:0] maze_t [0:63];

  // Default map: no interior walls except the one between (3,3) and (4,3).
  function automatic maze_t build_maze();
    maze_t m;
    for (int i = 0; i < 64; i++) begin
      m[i] = 4'b0000;
    end
    m[{3'd3, 3'd3}] = 4'b0100;  // east wall of (3,3)
    m[{3'd3, 3'd4}] = 4'b0001;  // west wall of (4,3)
    return m;
  endfunction

  localparam maze_t MAZE = build_maze();

  // Wall nibble {N,E,S,W} of cell (x,y); the grid edge is always walled so
  // 3-bit wrap-around moves can never be taken.
  function automatic logic [3:0] wall_nibble(input logic [2:0] x, input logic [2:0] y);
    logic [3:0] w;
    w = MAZE[{y, x}];
    if (y == 3'd7) w[3] = 1'b1; else w[3] = w[3];
    if (x == 3'd7) w[2] = 1'b1; else w[2] = w[2];
    if (y == 3'd0) w[1] = 1'b1; else w[1] = w[1];
    if (x == 3'd0) w[0] = 1'b1; else w[0] = w[0];
    return w;
  endfunction

  // Wall bit in heading d (N is the MSB of the nibble).
  function automatic logic wall_in_dir(input logic [3:0] w, input logic [1:0] d);
    logic b;
    case (d)
      N:       b = w[3];
      E:       b = w[2];
      S:       b = w[1];
      W:       b = w[0];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) r = v;
    else               r = v + 16'd1;
    return r;
  endfunction

endpackage

// File: rtl/robo_sensor.sv
// robo_sensor: combinational pose -> {h,l} decode from the maze map.
// Ports:
//   pos_x, pos_y : current cell (registered pose from the top)
//   dir          : current heading
//   h            : wall directly ahead
//   l            : wall on the left, i.e. in heading (dir+3) mod 4
module robo_sensor
  import robo_pkg::*;
(
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  input  logic [1:0] dir,
  output logic       h,
  output logic       l
);

  logic [3:0] walls_s;
  logic [1:0] left_dir_s;

  // Look up the current cell and pick the ahead/left wall bits.
  always_comb begin
    walls_s    = wall_nibble(pos_x, pos_y);
    left_dir_s = dir + 2'd3;
    h          = wall_in_dir(walls_s, dir);
    l          = wall_in_dir(walls_s, left_dir_s);
  end

endmodule

// File: rtl/robo_ambiente.sv
// robo_ambiente: maze/world emulator closing the loop around the wall-following
// controller. Consumes motion commands, produces wall sensors from the
// registered pose.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : step enable
//   f, g          : forward / turn-right commands
//   h, l          : wall ahead / wall on left (from registered pose only)
//   pos_x, pos_y  : current cell
//   dir           : current heading (0=N,1=E,2=S,3=W)
//   passos        : accepted moves plus turns, saturating
//   colisao, erro : sticky collision / illegal-command flags
//   chegou        : sticky goal-reached flag; freezes all state
module robo_ambiente
  import robo_pkg::*;
#(
  parameter logic [2:0] START_X   = 3'd0,
  parameter logic [2:0] START_Y   = 3'd0,
  parameter logic [1:0] START_DIR = 2'd0,
  parameter logic [2:0] GOAL_X    = 3'd7,
  parameter logic [2:0] GOAL_Y    = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        f,
  input  logic        g,
  output logic        h,
  output logic        l,
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [1:0]  dir,
  output logic [15:0] passos,
  output logic        colisao,
  output logic        erro,
  output logic        chegou
);

  state_t      state_r,   state_nx_s;
  logic [2:0]  pos_x_r,   pos_x_nx_s;
  logic [2:0]  pos_y_r,   pos_y_nx_s;
  logic [1:0]  dir_r,     dir_nx_s;
  logic [15:0] passos_r,  passos_nx_s;
  logic        colisao_r, colisao_nx_s;
  logic        erro_r,    erro_nx_s;
  logic        h_s, l_s;
  logic        at_goal_s;

  robo_sensor u_sensor (
    .pos_x (pos_x_r),
    .pos_y (pos_y_r),
    .dir   (dir_r),
    .h     (h_s),
    .l     (l_s)
  );

  // Next pose, counter and flags. Reaching the goal is checked before the
  // command so the command on the goal-detect edge is ignored; the goal
  // check does not depend on en so a start-on-goal rises on the first edge.
  always_comb begin
    state_nx_s   = state_r;
    pos_x_nx_s   = pos_x_r;
    pos_y_nx_s   = pos_y_r;
    dir_nx_s     = dir_r;
    passos_nx_s  = passos_r;
    colisao_nx_s = colisao_r;
    erro_nx_s    = erro_r;
    at_goal_s    = (pos_x_r == GOAL_X) && (pos_y_r == GOAL_Y);

    if (state_r == ST_RUN) begin
      if (at_goal_s) begin
        state_nx_s = ST_DONE;
      end else if (en) begin
        case ({f, g})
          CMD_FWD: begin
            if (h_s) begin
              colisao_nx_s = 1'b1;
            end else begin
              passos_nx_s = sat_inc16(passos_r);
              case (dir_r)
                N:       pos_y_nx_s = pos_y_r + 3'd1;
                E:       pos_x_nx_s = pos_x_r + 3'd1;
                S:       pos_y_nx_s = pos_y_r - 3'd1;
                W:       pos_x_nx_s = pos_x_r - 3'd1;
                default: pos_x_nx_s = pos_x_r;
              endcase
            end
          end
          CMD_TURN: begin
            dir_nx_s    = dir_r + 2'd1;
            passos_nx_s = sat_inc16(passos_r);
          end
          CMD_ERR:  erro_nx_s  = 1'b1;
          default:  state_nx_s = state_r;
        endcase
      end else begin
        state_nx_s = state_r;
      end
    end else begin
      state_nx_s = ST_DONE;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      pos_x_r   <= START_X;
      pos_y_r   <= START_Y;
      dir_r     <= START_DIR;
      passos_r  <= 16'd0;
      colisao_r <= 1'b0;
      erro_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      pos_x_r   <= pos_x_nx_s;
      pos_y_r   <= pos_y_nx_s;
      dir_r     <= dir_nx_s;
      passos_r  <= passos_nx_s;
      colisao_r <= colisao_nx_s;
      erro_r    <= erro_nx_s;
    end
  end

  assign h       = h_s;
  assign l       = l_s;
  assign pos_x   = pos_x_r;
  assign pos_y   = pos_y_r;
  assign dir     = dir_r;
  assign passos  = passos_r;
  assign colisao = colisao_r;
  assign erro    = erro_r;
  assign chegou  = (state_r == ST_DONE);

endmodule

// File: tb/tb_robo_ambiente.sv
// Directed self-checking bench for robo_ambiente: one default-parameter
// instance (a) walks the border to the goal, one instance (b) starts at
// (3,3,E) facing the interior wall.
module tb_robo_ambiente;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, f_a = 1'b0, g_a = 1'b0;
  logic en_b = 1'b0, f_b = 1'b0, g_b = 1'b0;

  logic        h_a, l_a, col_a, err_a, che_a;
  logic [2:0]  x_a, y_a;
  logic [1:0]  d_a;
  logic [15:0] p_a;
  logic        h_b, l_b, col_b, err_b, che_b;
  logic [2:0]  x_b, y_b;
  logic [1:0]  d_b;
  logic [15:0] p_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  robo_ambiente dut_a (
    .clk(clk), .rst(rst), .en(en_a), .f(f_a), .g(g_a),
    .h(h_a), .l(l_a), .pos_x(x_a), .pos_y(y_a), .dir(d_a),
    .passos(p_a), .colisao(col_a), .erro(err_a), .chegou(che_a)
  );

  robo_ambiente #(.START_X(3'd3), .START_Y(3'd3), .START_DIR(2'd1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .f(f_b), .g(g_b),
    .h(h_b), .l(l_b), .pos_x(x_b), .pos_y(y_b), .dir(d_b),
    .passos(p_b), .colisao(col_b), .erro(err_b), .chegou(che_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive instance a for one clock and sample #1 after the edge.
  task automatic step_a(input logic e, input logic ff, input logic gg);
    en_a = e; f_a = ff; g_a = gg;
    @(posedge clk); #1;
    en_a = 1'b0; f_a = 1'b0; g_a = 1'b0;
  endtask

  task automatic step_b(input logic e, input logic ff, input logic gg);
    en_b = e; f_b = ff; g_b = gg;
    @(posedge clk); #1;
    en_b = 1'b0; f_b = 1'b0; g_b = 1'b0;
  endtask

  task automatic check_pose_a(input string tag, input logic [2:0] x, input logic [2:0] y,
                              input logic [1:0] d, input logic [15:0] p);
    check_eq({tag, ".x"}, {29'd0, x_a}, {29'd0, x});
    check_eq({tag, ".y"}, {29'd0, y_a}, {29'd0, y});
    check_eq({tag, ".dir"}, {30'd0, d_a}, {30'd0, d});
    check_eq({tag, ".passos"}, {16'd0, p_a}, {16'd0, p});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    @(posedge clk); #1;
    check_pose_a("rst", 3'd0, 3'd0, 2'd0, 16'd0);
    check_eq("rst.h", {31'd0, h_a}, 32'd0);
    check_eq("rst.l", {31'd0, l_a}, 32'd1);
    check_eq("rst.flags", {29'd0, col_a, err_a, che_a}, 32'd0);
    rst = 1'b0;

    // en=0 with f=1 holds everything.
    step_a(1'b0, 1'b1, 1'b0);
    check_pose_a("en0", 3'd0, 3'd0, 2'd0, 16'd0);

    // Walk north to the top edge.
    step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("north1", 3'd0, 3'd1, 2'd0, 16'd1);
    for (int i = 0; i < 6; i++) step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("north7", 3'd0, 3'd7, 2'd0, 16'd7);
    check_eq("north7.h", {31'd0, h_a}, 32'd1);
    check_eq("north7.l", {31'd0, l_a}, 32'd1);
    check_eq("north7.col", {31'd0, col_a}, 32'd0);

    // Bump the top wall.
    step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("bump", 3'd0, 3'd7, 2'd0, 16'd7);
    check_eq("bump.col", {31'd0, col_a}, 32'd1);

    // Turn east.
    step_a(1'b1, 1'b0, 1'b1);
    check_pose_a("turnE", 3'd0, 3'd7, 2'd1, 16'd8);
    check_eq("turnE.h", {31'd0, h_a}, 32'd0);
    check_eq("turnE.l", {31'd0, l_a}, 32'd1);

    // Walk east to the goal.
    for (int i = 0; i < 6; i++) step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("east6", 3'd6, 3'd7, 2'd1, 16'd14);
    step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("east7", 3'd7, 3'd7, 2'd1, 16'd15);
    check_eq("east7.chegou", {31'd0, che_a}, 32'd0);
    step_a(1'b1, 1'b0, 1'b1);
    check_pose_a("goal", 3'd7, 3'd7, 2'd1, 16'd15);
    check_eq("goal.chegou", {31'd0, che_a}, 32'd1);
    step_a(1'b1, 1'b0, 1'b1);
    check_pose_a("frozen", 3'd7, 3'd7, 2'd1, 16'd15);
    check_eq("frozen.flags", {29'd0, col_a, err_a, che_a}, 32'd5);

    // Illegal {f,g}=11 at reset pose.
    do_reset();
    check_eq("rst2.flags", {29'd0, col_a, err_a, che_a}, 32'd0);
    step_a(1'b1, 1'b1, 1'b1);
    check_pose_a("err", 3'd0, 3'd0, 2'd0, 16'd0);
    check_eq("err.flags", {29'd0, col_a, err_a, che_a}, 32'd2);

    // Reset during a forward command: async override, then reset pose acts.
    do_reset();
    step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("pre_mid", 3'd0, 3'd1, 2'd0, 16'd1);
    en_a = 1'b1; f_a = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_pose_a("mid_rst", 3'd0, 3'd0, 2'd0, 16'd0);
    @(posedge clk); #1;
    check_pose_a("mid_rst_hold", 3'd0, 3'd0, 2'd0, 16'd0);
    rst = 1'b0;
    step_a(1'b1, 1'b1, 1'b0);
    check_pose_a("post_rst", 3'd0, 3'd1, 2'd0, 16'd1);

    // Instance b: interior wall east of (3,3); b was reset above too.
    check_eq("b.h", {31'd0, h_b}, 32'd1);
    check_eq("b.l", {31'd0, l_b}, 32'd0);
    step_b(1'b1, 1'b1, 1'b0);
    check_eq("b.bump.x", {29'd0, x_b}, 32'd3);
    check_eq("b.bump.col", {31'd0, col_b}, 32'd1);
    check_eq("b.bump.passos", {16'd0, p_b}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("b.rst.col", {31'd0, col_b}, 32'd0);
    check_eq("b.rst.dir", {30'd0, d_b}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    step_b(1'b1, 1'b0, 1'b1);
    check_eq("b.turnS.dir", {30'd0, d_b}, 32'd2);
    check_eq("b.turnS.h", {31'd0, h_b}, 32'd0);
    check_eq("b.turnS.l", {31'd0, l_b}, 32'd1);
    check_eq("b.turnS.passos", {16'd0, p_b}, 32'd1);

    // Saturate passos with turns: 1 + 65536 turns clamps at FFFF.
    en_b = 1'b1; g_b = 1'b1;
    for (int i = 0; i < 65536; i++) @(posedge clk);
    #1;
    en_b = 1'b0; g_b = 1'b0;
    check_eq("b.sat.passos", {16'd0, p_b}, 32'h0000FFFF);
    check_eq("b.sat.dir", {30'd0, d_b}, 32'd2);
    check_eq("b.sat.chegou", {31'd0, che_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/robo_ambiente.md
# robo_ambiente

Maze/world emulator that closes the loop around the wall-following robot controller. It consumes the controller's motion commands (`f` forward, `g` turn) and produces the controller's sensor inputs (`h` wall ahead, `l` wall on left) from a registered robot pose and a fixed maze map. It sits beside `robo_v` in simulation and FPGA demo tops and reports pose, step count, collision, command error and goal arrival.

## Interface

Parameters:
- `START_X`, default 0: reset column (0..7).
- `START_Y`, default 0: reset row (0..7).
- `START_DIR`, default 0: reset heading (0=N, 1=E, 2=S, 3=W).
- `GOAL_X`, default 7: goal column.
- `GOAL_Y`, default 7: goal row.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: step enable; pose updates only on cycles with `en=1`.
- `f` in 1: move-forward command from the controller.
- `g` in 1: turn-right command from the controller.
- `h` out 1: wall directly ahead of the robot.
- `l` out 1: wall on the robot's left side.
- `pos_x` out 3: current column.
- `pos_y` out 3: current row.
- `dir` out 2: current heading.
- `passos` out 16: accepted moves plus turns, saturating at 16'hFFFF.
- `colisao` out 1: sticky; a forward move was attempted into a wall.
- `erro` out 1: sticky; `f` and `g` were both 1 on an enabled cycle.
- `chegou` out 1: sticky; the pose reached the goal cell.

## Operation

- Grid is 8x8. Moving north is y+1, east is x+1, south is y-1, west is x-1.
- Map: 64 entries of 4 wall bits {N,E,S,W}, indexed by `{y,x}`. Outer border walls are forced to 1 regardless of map contents.
- `h` = wall bit of the current cell in direction `dir`.
- `l` = wall bit of the current cell in direction `(dir+3) mod 4`.
- Both `h` and `l` are decoded from registered pose only. They have no combinational path from `f`, `g` or `en`. This is mandatory because the controller's outputs are combinational in `h` and `l`.
- Enabled cycle (`en=1`, `chegou=0`), by `{f,g}`:
  - 00: hold; `passos` unchanged.
  - 10, h=0: advance one cell along `dir`; `passos`+1.
  - 10, h=1: hold pose; set `colisao`; `passos` unchanged.
  - 01: `dir` <= `(dir+1) mod 4`; `passos`+1.
  - 11: hold pose; set `erro`; `passos` unchanged.
- `en=0`: all registers hold.
- Once `chegou=1`, pose, `passos` and the flags freeze until reset.
- `chegou` sets on the clock edge after the pose register equals (`GOAL_X`,`GOAL_Y`). If the start cell is the goal, `chegou` rises on the first edge after reset release.
- Border walls make wrap-around unreachable. Arithmetic is 3-bit, and an illegal step is always blocked by `h=1`.

## Timing

- Reset values: `pos_x`=`START_X`, `pos_y`=`START_Y`, `dir`=`START_DIR`, `passos`=0, `colisao`=`erro`=`chegou`=0. `h` and `l` reflect the start pose immediately.
- Command-to-pose latency is 1 cycle. `h` and `l` reflect the new pose in the same cycle the pose register updates.
- Asserting `rst` mid-move overrides any pending update. On release, the first enabled edge acts on the reset pose.
- Simultaneous goal arrival and command: the move into the goal is taken. The command on the following edge is ignored because `chegou` is set.

## Structure

- Package `robo_pkg`:
  - heading constants `N`, `E`, `S`, `W`
  - `{f,g}` command encodings
  - maze constant `MAZE[0:63]` (default: border walls only, plus interior wall between (3,3) and (4,3), i.e. E of (3,3) and W of (4,3))
  - function returning the border-forced wall nibble for a cell
- One natural sub-module, `robo_sensor`: combinational pose-to-`{h,l}` decode from the map. The top holds the pose FSM, counter and flags.

## Test plan

- Reset with defaults -> pose (0,0,N), `h`=0, `l`=1, `passos`=0, all flags 0.
- `{f,g}`=10 for 7 enabled cycles from reset -> pose (0,7,N), `h`=1, `l`=1, `passos`=7.
- From (0,7,N), `{f,g}`=10 once -> pose unchanged, `colisao`=1, `passos`=7. Then `g`=1 -> `dir`=E, `h`=0, `l`=1, `passos`=8.
- From (0,7,E), 7 forward moves -> (7,7), `chegou`=1 one cycle after arrival. A further `g`=1 leaves `dir`=E and `passos`=15.
- `{f,g}`=11 at reset pose -> `erro`=1, pose unchanged. `en`=0 with `f`=1 -> no change.
- Pose (3,3,E) via parameters: `h`=1 from the interior wall. Assert `rst` during a forward command -> pose returns to the START values with `colisao`=0.
- Full-loop run with `robo_v` instantiated from (0,0,N) -> `chegou`=1 within 64 steps.
